output_deskewer: RTL and testbench
==================================

Name: output_deskewer

Overview:
- Receive end of the systolic-array datapath, placed at the south edge of the PE grid.
- Column results leave the array staggered: lane i trails lane 0 by i cycles. This block delays each lane by the complement, so a full result row is presented in a single cycle.
- Aligned rows are buffered in a 2-entry FIFO and emitted on a valid/ready interface with a per-tile last marker.

Parameters:
- MATRIX_SIZE, 2, number of lanes (array columns) and number of rows per tile; must be ≥1.
- DATA_SIZE, 32, bit width of each result element.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable_in  in  1  advances the deskew delay lines; when low, lines hold and valid_in is ignored.
- valid_in  in  1  lane-0 element of a new row is present this cycle; lane i's element arrives i enabled cycles later.
- data_in  in  [DATA_SIZE-1:0] x MATRIX_SIZE  skewed lane data from the array.
- out_ready  in  1  downstream accepts a row.
- out_valid  out  1  the FIFO head row is valid.
- out_data  out  [DATA_SIZE-1:0] x MATRIX_SIZE  aligned row at the FIFO head.
- out_last  out  1  out_valid row is row MATRIX_SIZE-1 of the current tile.
- overflow  out  1  sticky; an aligned row was dropped because the FIFO was full.

Behaviour:
- Lane delay: lane i passes through D_i = MATRIX_SIZE-1-i register stages. Lane MATRIX_SIZE-1 has zero stages and is used combinationally.
- Delay stages and the valid pipeline shift only when enable_in=1.
- Valid pipeline: valid_in passes through MATRIX_SIZE-1 stages, gated by enable_in. The aligned row is "arriving" in a cycle when the pipeline output is 1 and enable_in=1. For MATRIX_SIZE=1, arriving = valid_in & enable_in.
- Push: an arriving row is written into the FIFO at that clock edge.
- Pop: occurs when out_valid & out_ready.
- Latency: with enable_in held high, an empty FIFO and valid_in at cycle T, out_valid rises at cycle T+MATRIX_SIZE. Each enable_in=0 cycle inside that window adds one cycle.
- Throughput: one row per cycle sustained while out_ready=1.
- FIFO: 2 entries, first in first out. out_data holds the head entry.
  - out_data is don't-care when out_valid=0; the bench must not check it then.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Full FIFO with push and pop in the same cycle: the pop frees a slot, the push is accepted, and overflow does not set.
- Full FIFO with push and no pop: the row is dropped, overflow sets, and the row counter does not advance.
- Empty FIFO with push and pop in the same cycle: pop has no effect because out_valid=0. The row is registered and presented next cycle; there is no bypass.
- Row counter: counts 0..MATRIX_SIZE-1 and advances on each pop.
  - out_last = out_valid & (count == MATRIX_SIZE-1).
  - The counter wraps to 0 after the last row is popped.
- overflow stays set until reset; there is no other clear.
- Reset, asserted at any time:
  - out_valid=0, out_last=0, overflow=0.
  - FIFO empty, row counter 0.
  - Valid pipeline cleared, so in-flight partial rows are discarded.
  - Data stages need no reset; their contents are don't-care.
  - Deassertion is synchronised externally. The first enabled edge after reset is a normal cycle.
- data_in lanes whose row is not yet valid are ignored. Garbage in delay stages never sets out_valid.

Test Plan:
- Single row, MATRIX_SIZE=4, out_ready=1. Drive row elements 0x10,0x11,0x12,0x13 on lanes 0..3 at cycles T..T+3 with valid_in at T. Required: out_valid for exactly one cycle at T+4, out_data={0x10,0x11,0x12,0x13}, out_last=0.
- Full tile back-to-back. Send rows r=0..3 with lane i element = 0x100*r+i and valid_in at T..T+3. Required: four consecutive out_valid cycles starting T+4, rows in order, out_last=1 only with row 3. A fifth row gives out_last=0 (counter wrapped).
- Stall. Same as the single-row test, but enable_in=0 for 2 cycles at T+1. Required: out_valid at T+6 and the row still correctly aligned.
- Backpressure and overflow. Hold out_ready=0 and send 3 rows. Required:
  - rows 0 and 1 are held with a stable head (row 0);
  - overflow rises the cycle after row 2 arrives;
  - on releasing out_ready, exactly rows 0 and 1 are emitted.
- Full FIFO with push and pop in the same cycle. Fill 2 entries, then set out_ready=1 in the cycle a third row arrives. Required: overflow stays 0 and rows 0, 1, 2 emerge in order.
- Reset mid-operation. Assert reset at T+2 of a row in flight and with 1 row queued. Required: out_valid=0 and overflow=0 immediately. After release, no stale row ever appears, and the next row sent has latency MATRIX_SIZE and out_last=0.

Source files
------------

// File: rtl/output_deskewer.sv
// -----------------------------------------------------------------------------
// output_deskewer
//
// Receive end of the systolic-array datapath, at the south edge of the PE grid.
// Column results leave the array staggered: lane i trails lane 0 by i enabled
// cycles. Each lane is delayed by the complement (MATRIX_SIZE-1-i stages), so a
// whole result row lines up in one cycle. Aligned rows go into a 2-entry FIFO
// and are emitted on a valid/ready interface with a per-tile last marker.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all control state
//   enable_in  advances the delay lines; when low, lines hold, valid_in ignored
//   valid_in   lane-0 element of a new row is present this cycle
//   data_in    skewed lane data, data_in[i] is lane i
//   out_ready  downstream accepts the head row
//   out_valid  FIFO head row is valid
//   out_data   aligned row at the FIFO head, out_data[i] is lane i
//   out_last   head row is row MATRIX_SIZE-1 of the current tile
//   overflow   sticky; an aligned row was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module output_deskewer #(
   parameter int MATRIX_SIZE = 2,
   parameter int DATA_SIZE   = 32
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  enable_in,
   input  logic                                  valid_in,
   input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_in,
   input  logic                                  out_ready,
   output logic                                  out_valid,
   output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_data,
   output logic                                  out_last,
   output logic                                  overflow
);

   localparam int            CW       = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
   localparam logic [CW-1:0] LAST_ROW = CW'(MATRIX_SIZE - 1);

   logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] aligned;
   logic                                  arriving;

   // ---------------------------------------------------------------------------
   // Lane delay lines: lane i gets MATRIX_SIZE-1-i stages, the last lane none.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
      localparam int D = MATRIX_SIZE - 1 - i;
      if (D == 0) begin : g_direct
         assign aligned[i] = data_in[i];
      end else begin : g_delay
         logic [DATA_SIZE-1:0] stage [D];

         // NOTE: pure datapath storage carries no reset; validity is tracked
         // separately by the valid pipeline, so stale contents are never seen.
         always_ff @(posedge clk) begin
            if (enable_in) begin
               stage[0] <= data_in[i];
               for (int k = 1; k < D; k++) begin
                  stage[k] <= stage[k-1];
               end
            end
         end

         assign aligned[i] = stage[D-1];
      end
   end

   // ---------------------------------------------------------------------------
   // Valid pipeline: tracks the row's lane-0 timing, so a row is "arriving"
   // exactly when its last lane is on data_in and every other lane is aligned.
   // ---------------------------------------------------------------------------
   if (MATRIX_SIZE == 1) begin : g_no_vpipe
      assign arriving = valid_in & enable_in;
   end else begin : g_vpipe
      logic [MATRIX_SIZE-2:0] vpipe;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vpipe <= '0;
         end else if (enable_in) begin
            // NOTE: non-blocking assignments make every stage read its
            // neighbour's old value, so the loop order does not matter.
            vpipe[0] <= valid_in;
            for (int k = 1; k < MATRIX_SIZE - 1; k++) begin
               vpipe[k] <= vpipe[k-1];
            end
         end
      end

      assign arriving = vpipe[MATRIX_SIZE-2] & enable_in;
   end

   // ---------------------------------------------------------------------------
   // 2-entry FIFO. A pop frees a slot in the same cycle, so a full FIFO with a
   // simultaneous pop still accepts the arriving row. No empty bypass.
   // ---------------------------------------------------------------------------
   logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] fifo_mem [2];
   logic                                  wr_ptr;
   logic                                  rd_ptr;
   logic [1:0]                            fifo_count;
   logic [CW-1:0]                         row_cnt;
   logic                                  full;
   logic                                  push;
   logic                                  pop;
   logic                                  drop;

   assign out_valid = (fifo_count != 2'd0);
   assign full      = (fifo_count == 2'd2);
   assign pop       = out_valid & out_ready;
   assign push      = arriving & (~full | pop);
   assign drop      = arriving & full & ~pop;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= aligned;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
         row_cnt    <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
            // Row counter tracks the position of the head row within its tile.
            if (row_cnt == LAST_ROW) begin
               row_cnt <= '0;
            end else begin
               row_cnt <= row_cnt + 1'b1;
            end
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   assign out_data = fifo_mem[rd_ptr];
   assign out_last = out_valid & (row_cnt == LAST_ROW);

endmodule

// File: tb/tb_output_deskewer.sv
// -----------------------------------------------------------------------------
// tb_output_deskewer
//
// Directed bench for output_deskewer with MATRIX_SIZE=4, DATA_SIZE=32.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, i.e. well away from the active edge. "Cycle c"
// is the interval following rising edge c of the stimulus sequence.
// Lane i of row r carries base + 0x100*r + i; unused lane slots carry a
// 0xDEAD_xxxx filler that must never surface.
// -----------------------------------------------------------------------------
module tb_output_deskewer;

   localparam int M = 4;
   localparam int W = 32;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                enable_in = 1'b0;
   logic                valid_in = 1'b0;
   logic [M-1:0][W-1:0] data_in = '0;
   logic                out_ready = 1'b0;
   logic                out_valid;
   logic [M-1:0][W-1:0] out_data;
   logic                out_last;
   logic                overflow;

   int                  checks = 0;
   int                  failures = 0;
   logic [W-1:0]        base = '0;

   output_deskewer #(
      .MATRIX_SIZE (M),
      .DATA_SIZE   (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable_in (enable_in),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Element value for row r on lane i; r < 0 means an unused filler slot.
   function automatic logic [W-1:0] lane_val(input int r, input int i);
      if (r < 0) return 32'hDEAD_0000 + 32'(i);
      return base + 32'h100 * 32'(r) + 32'(i);
   endfunction

   // Row present on lane i in cycle k when n rows start at cycles 0..n-1.
   function automatic int row_on(input int k, input int i, input int n);
      int d;
      d = k - i;
      return (d >= 0 && d < n) ? d : -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic en, input logic vin,
                      input int r0, input int r1, input int r2, input int r3);
      enable_in  = en;
      valid_in   = vin;
      data_in[0] = lane_val(r0, 0);
      data_in[1] = lane_val(r1, 1);
      data_in[2] = lane_val(r2, 2);
      data_in[3] = lane_val(r3, 3);
      tick();
   endtask

   // Cycle k of a skewed burst of n rows, enable held high.
   task automatic send_skewed(input int k, input int n);
      cyc(1'b1, k < n, row_on(k, 0, n), row_on(k, 1, n), row_on(k, 2, n), row_on(k, 3, n));
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_row(input string tag, input logic ev, input logic el, input int r);
      chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, ev});
      chk({tag, ".last"},  {31'b0, out_last},  {31'b0, el});
      if (ev) begin
         for (int i = 0; i < M; i++) begin
            chk($sformatf("%s.lane%0d", tag, i), out_data[i], lane_val(r, i));
         end
      end
   endtask

   task automatic chk_ovf(input string tag, input logic eo);
      chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, eo});
   endtask

   task automatic do_reset();
      enable_in = 1'b0;
      valid_in  = 1'b0;
      reset     = 1'b1;
      tick();
      reset     = 1'b0;
   endtask

   initial begin
      int c;

      // ---------------- reset state ----------------
      tick();
      tick();
      chk_row("reset", 1'b0, 1'b0, 0);
      chk_ovf("reset", 1'b0);
      reset = 1'b0;

      // ---------------- single row, latency M ----------------
      base      = 32'h10;
      out_ready = 1'b1;
      do_reset();
      for (int k = 0; k <= 4; k++) begin
         send_skewed(k, 1);
         c = k + 1;
         if (c == 4) chk_row($sformatf("single.c%0d", c), 1'b1, 1'b0, 0);
         else        chk_row($sformatf("single.c%0d", c), 1'b0, 1'b0, 0);
      end

      // ---------------- full tile plus a wrapped fifth row ----------------
      base = 32'h0;
      do_reset();
      for (int k = 0; k <= 8; k++) begin
         send_skewed(k, 5);
         c = k + 1;
         if (c >= 4 && c <= 8) chk_row($sformatf("tile.c%0d", c), 1'b1, (c - 4) == 3, c - 4);
         else                  chk_row($sformatf("tile.c%0d", c), 1'b0, 1'b0, 0);
      end

      // ---------------- stall: two disabled cycles at T+1 ----------------
      base = 32'h30;
      do_reset();
      cyc(1'b1, 1'b1,  0, -1, -1, -1); chk_row("stall.c1", 1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, -1, -1, -1, -1); chk_row("stall.c2", 1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, -1, -1, -1, -1); chk_row("stall.c3", 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, -1,  0, -1, -1); chk_row("stall.c4", 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, -1, -1,  0, -1); chk_row("stall.c5", 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, -1, -1, -1,  0); chk_row("stall.c6", 1'b1, 1'b0, 0);
      cyc(1'b1, 1'b0, -1, -1, -1, -1); chk_row("stall.c7", 1'b0, 1'b0, 0);

      // ---------------- full FIFO with push and pop together ----------------
      base      = 32'h50;
      out_ready = 1'b0;
      do_reset();
      for (int k = 0; k <= 7; k++) begin
         out_ready = (k >= 5);
         send_skewed(k, 3);
         c = k + 1;
         if (c == 4 || c == 5) chk_row($sformatf("pp.c%0d", c), 1'b1, 1'b0, 0);
         else if (c == 6)      chk_row($sformatf("pp.c%0d", c), 1'b1, 1'b0, 1);
         else if (c == 7)      chk_row($sformatf("pp.c%0d", c), 1'b1, 1'b0, 2);
         else                  chk_row($sformatf("pp.c%0d", c), 1'b0, 1'b0, 0);
         chk_ovf($sformatf("pp.c%0d", c), 1'b0);
      end

      // ---------------- backpressure and overflow ----------------
      base      = 32'h40;
      out_ready = 1'b0;
      do_reset();
      for (int k = 0; k <= 5; k++) begin
         send_skewed(k, 3);
         c = k + 1;
         if (c >= 4) chk_row($sformatf("bp.c%0d", c), 1'b1, 1'b0, 0);
         else        chk_row($sformatf("bp.c%0d", c), 1'b0, 1'b0, 0);
         chk_ovf($sformatf("bp.c%0d", c), c >= 6);
      end
      cyc(1'b1, 1'b0, -1, -1, -1, -1);
      chk_row("bp.hold", 1'b1, 1'b0, 0);
      chk_ovf("bp.hold", 1'b1);
      out_ready = 1'b1;
      cyc(1'b1, 1'b0, -1, -1, -1, -1);
      chk_row("bp.rel1", 1'b1, 1'b0, 1);
      cyc(1'b1, 1'b0, -1, -1, -1, -1);
      chk_row("bp.rel2", 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, -1, -1, -1, -1);
      chk_row("bp.rel3", 1'b0, 1'b0, 0);
      chk_ovf("bp.sticky", 1'b1);
      // One more row advances the tile counter to its last position (3).
      cyc(1'b1, 1'b1,  3, -1, -1, -1);
      cyc(1'b1, 1'b0, -1,  3, -1, -1);
      cyc(1'b1, 1'b0, -1, -1,  3, -1);
      cyc(1'b1, 1'b0, -1, -1, -1,  3);
      chk_row("bp.row3", 1'b1, 1'b0, 3);
      cyc(1'b1, 1'b0, -1, -1, -1, -1);
      chk_row("bp.row3_gone", 1'b0, 1'b0, 0);

      // ---------------- reset mid-operation ----------------
      // Row A (index 0) starts at cycle 0 and queues; row B (index 1) starts
      // at cycle 4 and is in flight when reset hits at cycle 6.
      base      = 32'h600;
      out_ready = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         cyc(1'b1, k == 0 || k == 4,
             (k == 0) ? 0 : (k == 4) ? 1 : -1,
             (k == 1) ? 0 : (k == 5) ? 1 : -1,
             (k == 2) ? 0 : -1,
             (k == 3) ? 0 : -1);
      end
      chk_row("mid.queued", 1'b1, 1'b1, 0);
      chk_ovf("mid.queued", 1'b1);
      reset = 1'b1;
      #1;
      chk_row("mid.async", 1'b0, 1'b0, 0);
      chk_ovf("mid.async", 1'b0);
      enable_in  = 1'b1;
      valid_in   = 1'b0;
      data_in[2] = lane_val(1, 2);
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      cyc(1'b1, 1'b0, -1, -1, -1, 1);
      chk_row("mid.post0", 1'b0, 1'b0, 0);
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b1, 1'b0, -1, -1, -1, -1);
         chk_row($sformatf("mid.post%0d", k), 1'b0, 1'b0, 0);
      end
      chk_ovf("mid.post", 1'b0);
      cyc(1'b1, 1'b1,  2, -1, -1, -1); chk_row("mid.new1", 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, -1,  2, -1, -1); chk_row("mid.new2", 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, -1, -1,  2, -1); chk_row("mid.new3", 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, -1, -1, -1,  2); chk_row("mid.new4", 1'b1, 1'b0, 2);
      cyc(1'b1, 1'b0, -1, -1, -1, -1); chk_row("mid.new5", 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
